// File: rtl/sram_arbiter_pkg.sv
// Shared constants and types for the board SRAM sequencer/arbiter.
// The core and the SRAM-based board tops import the same values.
package sram_arbiter_pkg;

  localparam int SRAM_AW        = 21;
  localparam int WAIT_DEFAULT   = 1;
  localparam int STARVE_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  typedef enum logic {
    PORT_CORE   = 1'b0,
    PORT_LOADER = 1'b1
  } port_t;

endpackage

// File: rtl/sram_arbiter_if.sv
// One requester port of the SRAM arbiter: level request held until the
// one-cycle ack, with the read data register returned alongside.
interface sram_arbiter_if #(
  parameter int AW = 19
);
  logic          req;
  logic          we;
  logic [AW-1:0] a;
  logic [7:0]    d;
  logic [7:0]    q;
  logic          ack;

  modport master (output req, we, a, d, input q, ack);
  modport slave  (input req, we, a, d, output q, ack);
endinterface

// File: rtl/sram_arbiter.sv
// Shares the single 8-bit async SRAM between the core and the loader and
// sequences SETUP / ACCESS (WAIT+1 cycles) / DONE strobe timing.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int AW     = 19,
  parameter int WAIT   = WAIT_DEFAULT,
  parameter int STARVE = STARVE_DEFAULT
) (
  input  logic               clock,
  input  logic               reset,
  sram_arbiter_if.slave      core,
  sram_arbiter_if.slave      loader,
  output logic [SRAM_AW-1:0] sramA,
  output logic [7:0]         sramDo,
  input  logic [7:0]         sramDi,
  output logic               sramDoe,
  output logic               sramOe,
  output logic               sramWe
);

  localparam logic [2:0] WAIT_W   = 3'(WAIT);
  localparam logic [3:0] STARVE_W = 4'(STARVE);

  state_t        state, state_nx;
  logic [2:0]    wait_cnt;
  logic [3:0]    starve_cnt;
  port_t         g_port;
  logic          g_we;
  logic [AW-1:0] g_addr;
  logic [7:0]    g_data;
  logic [7:0]    c_q, l_q;
  logic          grant_core, grant_loader;

  // Arbitration and next state.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
    state_nx     = state;
    grant_core   = 1'b0;
    grant_loader = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (core.req && !(loader.req && starve_cnt == STARVE_W)) begin
          grant_core = 1'b1;
        end else if (loader.req) begin
          grant_loader = 1'b1;
        end
        if (grant_core || grant_loader) state_nx = ST_SETUP;
      end
      ST_SETUP:  state_nx = ST_ACCESS;
      ST_ACCESS: if (wait_cnt == 3'd0) state_nx = ST_DONE;
      ST_DONE:   state_nx = ST_IDLE;
    endcase
  end

  // Strobes and acks decode straight from the state register, so they
  // change only on clock edges and return high together with reset.
  always_comb begin
    sramOe     = 1'b1;
    sramWe     = 1'b1;
    sramDoe    = 1'b0;
    core.ack   = 1'b0;
    loader.ack = 1'b0;
    if (state != ST_IDLE) sramDoe = g_we;
    if (state == ST_ACCESS) begin
      sramOe = g_we;
      sramWe = !g_we;
    end
    if (state == ST_DONE) begin
      core.ack   = (g_port == PORT_CORE);
      loader.ack = (g_port == PORT_LOADER);
    end
  end

  assign sramA    = SRAM_AW'(g_addr);
  assign sramDo   = g_data;
  assign core.q   = c_q;
  assign loader.q = l_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      wait_cnt   <= '0;
      starve_cnt <= '0;
      g_port     <= PORT_CORE;
      g_we       <= 1'b0;
      g_addr     <= '0;
      g_data     <= '0;
      c_q        <= '0;
      l_q        <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register here sees pre-edge values.
      state <= state_nx;
      unique case (state)
        ST_IDLE: begin
          if (grant_core) begin
            g_port <= PORT_CORE;
            g_we   <= core.we;
            g_addr <= core.a;
            g_data <= core.d;
          end else if (grant_loader) begin
            g_port <= PORT_LOADER;
            g_we   <= loader.we;
            g_addr <= loader.a;
            g_data <= loader.d;
          end
          // The loader only accrues starvation while it is actually waiting.
          if (grant_loader || !loader.req) begin
            starve_cnt <= '0;
          end else if (grant_core && starve_cnt != STARVE_W) begin
            starve_cnt <= starve_cnt + 4'd1;
          end
        end
        ST_SETUP: wait_cnt <= WAIT_W;
        ST_ACCESS: begin
          if (wait_cnt != 3'd0) begin
            wait_cnt <= wait_cnt - 3'd1;
          end else if (!g_we) begin
            if (g_port == PORT_CORE) c_q <= sramDi;
            else                     l_q <= sramDi;
          end
        end
        ST_DONE: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench: two arbiters (WAIT=1 and WAIT=0) against a
// transaction-level model plus directed literal expectations.
module tb_sram_arbiter;
  import sram_arbiter_pkg::*;

  localparam int AW     = 19;
  localparam int STARVE = 8;
  localparam int MEM_N  = 1 << AW;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic          c_req [2], c_we [2], l_req [2], l_we [2];
  logic [AW-1:0] c_a [2], l_a [2];
  logic [7:0]    c_d [2], l_d [2], c_q [2], l_q [2];
  logic          c_ack [2], l_ack [2];
  logic [20:0]   sram_a [2];
  logic [7:0]    sram_do [2], sram_di [2];
  logic          sram_doe [2], sram_oe [2], sram_we [2];
  logic [7:0]    mem [2][MEM_N];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int W = (g == 0) ? 1 : 0;

    sram_arbiter_if #(.AW(AW)) core_if ();
    sram_arbiter_if #(.AW(AW)) ldr_if ();

    assign core_if.req = c_req[g];
    assign core_if.we  = c_we[g];
    assign core_if.a   = c_a[g];
    assign core_if.d   = c_d[g];
    assign c_q[g]      = core_if.q;
    assign c_ack[g]    = core_if.ack;
    assign ldr_if.req  = l_req[g];
    assign ldr_if.we   = l_we[g];
    assign ldr_if.a    = l_a[g];
    assign ldr_if.d    = l_d[g];
    assign l_q[g]      = ldr_if.q;
    assign l_ack[g]    = ldr_if.ack;
    assign sram_di[g]  = mem[g][sram_a[g][AW-1:0]];

    sram_arbiter #(.AW(AW), .WAIT(W), .STARVE(STARVE)) dut (
      .clock  (clock),
      .reset  (reset),
      .core   (core_if),
      .loader (ldr_if),
      .sramA  (sram_a[g]),
      .sramDo (sram_do[g]),
      .sramDi (sram_di[g]),
      .sramDoe(sram_doe[g]),
      .sramOe (sram_oe[g]),
      .sramWe (sram_we[g])
    );

    // Transaction model: an access occupies offsets 0 (grant) .. 3+W (ack).
    initial begin : model
      bit            valid = 0, busy = 0, port = 0, we_l = 0;
      int            off = 0, starve = 0;
      logic [AW-1:0] addr = '0;
      logic [7:0]    data = '0, mq_c = '0, mq_l = '0;
      bit            e_oe, e_we, e_ca, e_la;
      for (int i = 0; i < MEM_N; i++) mem[g][i] = 8'h00;
      mem[g][19'h04000] = 8'hA5;
      mem[g][19'h00000] = 8'h11;
      mem[g][19'h00001] = 8'h22;
      mem[g][19'h00002] = 8'h33;
      mem[g][19'h00003] = 8'h44;
      mem[g][19'h00010] = 8'h6B;
      forever begin
        @(negedge clock);
        if (valid) begin
          e_oe = 1; e_we = 1; e_ca = 0; e_la = 0;
          if (busy && off >= 2 && off <= 2 + W) begin
            e_oe = we_l;
            e_we = !we_l;
          end
          if (busy && off == 3 + W) begin
            e_ca = !port;
            e_la = port;
          end
          check($sformatf("i%0d_sramOe", g), sram_oe[g], e_oe);
          check($sformatf("i%0d_sramWe", g), sram_we[g], e_we);
          check($sformatf("i%0d_sramDoe", g), sram_doe[g], busy && we_l);
          check($sformatf("i%0d_cAck", g), c_ack[g], e_ca);
          check($sformatf("i%0d_lAck", g), l_ack[g], e_la);
          check($sformatf("i%0d_cQ", g), c_q[g], mq_c);
          check($sformatf("i%0d_lQ", g), l_q[g], mq_l);
          if (busy) check($sformatf("i%0d_sramA", g), sram_a[g], {2'b00, addr});
          if (busy && we_l) check($sformatf("i%0d_sramDo", g), sram_do[g], data);
        end
        if (sram_we[g] === 1'b0) mem[g][sram_a[g][AW-1:0]] = sram_do[g];
        if (reset) begin
          valid = 1; busy = 0; off = 0; starve = 0; port = 0; we_l = 0;
          addr = '0; data = '0; mq_c = '0; mq_l = '0;
        end else if (!busy) begin
          if (!l_req[g]) starve = 0;
          if (c_req[g] && !(l_req[g] && starve == STARVE)) begin
            port = 0; we_l = c_we[g]; addr = c_a[g]; data = c_d[g];
            if (l_req[g]) starve = (starve < STARVE) ? starve + 1 : STARVE;
            busy = 1; off = 1;
          end else if (l_req[g]) begin
            port = 1; we_l = l_we[g]; addr = l_a[g]; data = l_d[g];
            starve = 0; busy = 1; off = 1;
          end
        end else begin
          if (off == 2 + W && !we_l) begin
            if (port) mq_l = mem[g][addr];
            else      mq_c = mem[g][addr];
          end
          if (off == 3 + W) busy = 0;
          else off++;
        end
      end
    end
  end

  typedef struct {
    int          lat, oe_lo, we_lo, doe_n, ack_n;
    logic [20:0] a_done;
    logic [7:0]  q_done;
    bit          ok;
  } acc_t;

  // One access on instance k; port 0 = core, 1 = loader. With corrupt set,
  // the core address/data are changed in the first ACCESS cycle.
  task automatic run_access(input int k, input bit port, input bit we, input logic [AW-1:0] a,
                            input logic [7:0] d, input bit corrupt, output acc_t r);
    logic ack;
    r = '{lat: 0, oe_lo: 0, we_lo: 0, doe_n: 0, ack_n: 0, a_done: '0, q_done: '0, ok: 0};
    @(posedge clock); #1;
    if (!port) begin c_we[k] = we; c_a[k] = a; c_d[k] = d; c_req[k] = 1; end
    else       begin l_we[k] = we; l_a[k] = a; l_d[k] = d; l_req[k] = 1; end
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      ack = port ? l_ack[k] : c_ack[k];
      if (sram_oe[k] === 1'b0) r.oe_lo++;
      if (sram_we[k] === 1'b0) r.we_lo++;
      if (sram_doe[k] === 1'b1) r.doe_n++;
      if (ack === 1'b1) begin
        r.ack_n++;
        r.a_done = sram_a[k];
        r.q_done = port ? l_q[k] : c_q[k];
        r.ok = 1;
        break;
      end
      r.lat++;
      if (corrupt && r.lat == 3) begin c_a[k] = 19'h00200; c_d[k] = 8'hEE; end
    end
    check("ack_seen", r.ok, 1);
    @(posedge clock); #1;
    if (!port) c_req[k] = 0; else l_req[k] = 0;
    @(negedge clock);
    ack = port ? l_ack[k] : c_ack[k];
    if (ack === 1'b1) r.ack_n++;
  endtask

  initial begin : stim
    acc_t       r;
    int         seq[$];
    int         last, t, idx;
    logic [7:0] exp_q [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int k = 0; k < 2; k++) begin
      c_req[k] = 0; c_we[k] = 0; c_a[k] = '0; c_d[k] = '0;
      l_req[k] = 0; l_we[k] = 0; l_a[k] = '0; l_d[k] = '0;
    end

    // Reset values.
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_sramA", sram_a[0], 21'h0);
    check("rst_sramDo", sram_do[0], 8'h00);
    check("rst_sramDoe", sram_doe[0], 1'b0);
    check("rst_sramOe", sram_oe[0], 1'b1);
    check("rst_sramWe", sram_we[0], 1'b1);
    check("rst_acks", {c_ack[0], l_ack[0]}, 2'b00);
    check("rst_q", {c_q[0], l_q[0]}, 16'h0000);
    @(posedge clock); #1;
    reset = 0;

    // Core read, WAIT=1.
    run_access(0, 0, 0, 19'h04000, 8'h00, 0, r);
    check("rd_latency", r.lat, 4);
    check("rd_cQ", r.q_done, 8'hA5);
    check("rd_oe_low", r.oe_lo, 2);
    check("rd_we_low", r.we_lo, 0);
    check("rd_ack_pulses", r.ack_n, 1);

    // Loader write to the top of the address range.
    run_access(0, 1, 1, 19'h7FFFF, 8'h3C, 0, r);
    check("wr_we_low", r.we_lo, 2);
    check("wr_oe_low", r.oe_lo, 0);
    check("wr_doe_cycles", r.doe_n, 4);
    check("wr_sramA", r.a_done, 21'h07FFFF);
    check("wr_mem", mem[0][19'h7FFFF], 8'h3C);
    check("wr_ack_pulses", r.ack_n, 1);
    check("wr_cQ_kept", c_q[0], 8'hA5);

    // Requester changes address/data mid-access.
    run_access(0, 0, 1, 19'h00100, 8'h77, 1, r);
    check("chg_sramA", r.a_done, 21'h000100);
    check("chg_mem_orig", mem[0][19'h00100], 8'h77);
    check("chg_mem_new", mem[0][19'h00200], 8'h00);

    // Both requesters held: 8 core grants, then 1 loader grant.
    @(posedge clock); #1;
    c_we[0] = 0; c_a[0] = 19'h00020; l_we[0] = 0; l_a[0] = 19'h00030;
    c_req[0] = 1; l_req[0] = 1;
    for (int i = 0; i < 400 && seq.size() < 18; i++) begin
      @(negedge clock);
      if (c_ack[0] === 1'b1) seq.push_back(0);
      if (l_ack[0] === 1'b1) seq.push_back(1);
    end
    @(posedge clock); #1;
    c_req[0] = 0; l_req[0] = 0;
    check("starve_grants", seq.size(), 18);
    for (int i = 0; i < seq.size(); i++) check($sformatf("starve_grant%0d", i), seq[i], (i % 9 == 8));

    // Reset during the first ACCESS cycle of a core write.
    repeat (2) @(posedge clock); #1;
    c_we[0] = 1; c_a[0] = 19'h00300; c_d[0] = 8'h55; c_req[0] = 1;
    repeat (2) @(posedge clock); #1;
    reset = 1;
    @(negedge clock);
    check("rst_mid_we_active", sram_we[0], 1'b0);
    @(posedge clock); #1;
    check("rst_mid_sramWe", sram_we[0], 1'b1);
    check("rst_mid_sramDoe", sram_doe[0], 1'b0);
    check("rst_mid_cAck", c_ack[0], 1'b0);
    check("rst_mid_sramA", sram_a[0], 21'h0);
    c_req[0] = 0;
    reset = 0;
    run_access(0, 0, 0, 19'h04000, 8'h00, 0, r);
    check("post_rst_latency", r.lat, 4);
    check("post_rst_cQ", r.q_done, 8'hA5);

    // WAIT=0: loader read, then back-to-back core reads.
    run_access(1, 1, 0, 19'h00010, 8'h00, 0, r);
    check("w0_latency", r.lat, 3);
    check("w0_lQ", r.q_done, 8'h6B);
    @(posedge clock); #1;
    c_we[1] = 0; c_a[1] = 19'h00000; c_req[1] = 1;
    last = 0; t = 0; idx = 0;
    for (int i = 0; i < 100 && idx < 4; i++) begin
      @(negedge clock);
      t++;
      if (c_ack[1] === 1'b1) begin
        check($sformatf("b2b_cQ%0d", idx), c_q[1], exp_q[idx]);
        check($sformatf("b2b_lQ%0d", idx), l_q[1], 8'h6B);
        if (idx > 0) check($sformatf("b2b_gap%0d", idx), t - last, 4);
        last = t;
        idx++;
        @(posedge clock); #1;
        if (idx < 4) c_a[1] = AW'(idx);
        else         c_req[1] = 0;
      end
    end
    check("b2b_count", idx, 4);

    repeat (4) @(posedge clock);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Sequencer and two-port arbiter for the board's single 8-bit asynchronous SRAM. It shares the SRAM between the ZX core (CPU/video memory port) and the ROM/image loader. It generates the SRAM strobe timing with a configurable number of wait states. It sits in the board top between the core/controller and the SRAM pins; the top only adds the tristate buffer and ties `sramUb`/`sramLb`.

## Interface
Parameters:
- `AW`, 19: requester address width; upper `21-AW` SRAM address bits are driven 0.
- `WAIT`, 1: extra access cycles with strobe active (0..7).
- `STARVE`, 8: consecutive core grants, with the loader pending, after which the loader is forced next (1..15).

Ports:
- `clock` in 1: system clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `cReq` in 1: core request, level, held until `cAck`.
- `cWe` in 1: core write (1) / read (0).
- `cA` in AW: core address.
- `cD` in 8: core write data.
- `cQ` out 8: core read data, valid from `cAck` until the next core read completes.
- `cAck` out 1: one-cycle completion pulse.
- `lReq`, `lWe`, `lA`, `lD`, `lQ`, `lAck`: loader port, same semantics and widths.
- `sramA` out 21: SRAM address.
- `sramDo` out 8: write data.
- `sramDi` in 8: SRAM data pins (read path).
- `sramDoe` out 1: top drives `sramDo` onto the pins when 1.
- `sramOe` out 1: active-low output enable.
- `sramWe` out 1: active-low write enable.

## Operation
- States: IDLE, SETUP, ACCESS, DONE.
- **IDLE**
  - Sample `cReq`/`lReq`.
  - Grant the core if `cReq`, unless `lReq` and the starve counter == `STARVE`; otherwise grant the loader if `lReq`.
  - Latch the granted port's address, data and direction into internal registers, then go to SETUP.
  - No request: stay in IDLE.
- **SETUP** (1 cycle)
  - `sramA` = latched address; `sramOe`=1, `sramWe`=1.
  - Write: `sramDoe`=1, `sramDo` = latched data.
- **ACCESS** (`WAIT`+1 cycles, down-counter)
  - Read: `sramOe`=0.
  - Write: `sramWe`=0, data held.
  - On the final ACCESS cycle, a read captures `sramDi` into the granted port's Q register.
- **DONE** (1 cycle)
  - Strobes return to 1; write keeps `sramDoe`=1 and address stable (hold time).
  - Ack pulses for the granted port. Return to IDLE.
- Starve counter:
  - +1 (saturating at `STARVE`) on each core grant while `lReq`=1.
  - Cleared on a loader grant, or in IDLE when `lReq`=0.
- Requester signals are latched at grant; later changes do not affect the in-flight access.
- A requester deasserts `req` in the cycle after `ack`. `req` still high in the IDLE cycle following DONE is treated as a new request.
- The Q register of the non-granted port is never modified.

## Timing
- Latency: request seen in IDLE at cycle n → ack at cycle n+3+`WAIT`. Back-to-back throughput is one access per 4+`WAIT` cycles.
- `sramA` and `sramDo` are stable from SETUP through DONE inclusive.
- `sramWe`/`sramOe` are never low in SETUP or DONE, and never both low.
- Reset values:
  - `sramA`=0, `sramDo`=0, `sramDoe`=0, `sramOe`=1, `sramWe`=1.
  - `cAck`=`lAck`=0, `cQ`=`lQ`=0.
  - State IDLE, counters 0.
- Reset asserted mid-access: on the next edge, all outputs return to reset values. The access is abandoned with no ack; the requester must re-request after reset.
- Simultaneous `cReq`/`lReq` with starve counter < `STARVE`: core wins.
- Exactly one ack per granted access; never both acks in the same cycle.

## Structure
- State encoding (2-bit), default `WAIT`/`STARVE` values and the 21-bit SRAM address width live in the shared `zx_mem` constants include. The core and the SRAM-based board tops use the same constants.
- Single module, no sub-modules: the FSM, wait counter, starve counter, grant latch and two Q registers. Tristate stays in the top.

## Test plan
- Core read, `WAIT`=1, SRAM model returns 8'hA5 at 19'h04000 → `cAck` 4 cycles after req; `cQ`=8'hA5; `sramOe` low exactly 2 cycles; `sramWe` stays 1.
- Loader write 8'h3C to 19'h7FFFF → `sramWe` low 2 cycles; `sramDoe`=1 from SETUP to DONE; `sramA`=21'h07FFFF; model holds 8'h3C; `lAck` one pulse.
- `cReq` and `lReq` held permanently, `STARVE`=8 → grant sequence of 8 core, 1 loader, repeating; no ack overlap.
- Requester changes `cA`/`cD` during ACCESS → SRAM sees the originally latched values; model content is unchanged at the new address.
- `reset` asserted in the first ACCESS cycle of a write → next edge `sramWe`=1, `sramDoe`=0; no `cAck`; arbiter accepts a new request 1 cycle after reset release.
- `WAIT`=0 back-to-back core reads of 19'h00000..19'h00003 → acks every 4 cycles; `lQ` unchanged throughout.
